regfile_mp: RTL

Parametrised multi-port register file, the successor to the 16x16 two-read/one-write file.
- Generalised width, depth and read-port count; second write port; optional registered reads.
- Per-register pending-write scoreboard for the decode/hazard stage.
- Sits between decode (reads, reservations) and writeback (two writeback lanes: ALU and memory).

---
 rtl/regfile_mp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports, two write
// lanes (lane 0 = ALU, lane 1 = MEM), a per-register pending-write scoreboard,
// same-cycle write bypass and an optional one-cycle registered read path.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int READ_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit ZR       = (ZERO_REG != 0);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end
    if (READ_LAT != 0 && READ_LAT != 1) begin : g_bad_read_lat
        $error("regfile_mp: READ_LAT must be 0 or 1");
    end

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              wr_ok0, wr_ok1, rsv_ok;

    assign wa0 = wr_addr[0 +: ADDR_W];
    assign wa1 = wr_addr[ADDR_W +: ADDR_W];
    assign wd0 = wr_data[0 +: DATA_W];
    assign wd1 = wr_data[DATA_W +: DATA_W];

    // A write or reservation aimed at a hard-wired zero register is dropped.
    assign wr_ok0 = wr_en[0] && !(ZR && wa0 == '0);
    assign wr_ok1 = wr_en[1] && !(ZR && wa1 == '0);
    assign rsv_ok = rsv_en && !(ZR && rsv_addr == '0);

    // Register storage: lane 0 then lane 1, so lane 1 wins on a shared address.
    // NOTE: the file must read as all-zero straight out of reset, so the array
    // gets a real asynchronous reset instead of relying on power-up contents;
    // non-blocking assignments let the later lane override the earlier one
    // while every reader in this edge still sees the old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
        end else begin
            if (wr_ok0) mem[wa0] <= wd0;
            if (wr_ok1) mem[wa1] <= wd1;
        end
    end

    // Scoreboard next state: writes clear, a reservation (newer producer) sets last.
    always_comb begin
        // NOTE: start from the current value so every path assigns busy_d and
        // no latch is inferred.
        busy_d = busy_q;
        if (wr_ok0) busy_d[wa0] = 1'b0;
        if (wr_ok1) busy_d[wa1] = 1'b0;
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        if (ZR)     busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d_c;
        logic              b_c;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        // Read mux with bypass; an in-flight write satisfies the dependency.
        always_comb begin
            d_c = mem[ra];
            b_c = busy_q[ra];
            if (wr_ok0 && wa0 == ra) begin
                d_c = wd0;
                b_c = 1'b0;
            end
            if (wr_ok1 && wa1 == ra) begin
                d_c = wd1;
                b_c = 1'b0;
            end
            if (ZR && ra == '0) begin
                d_c = '0;
                b_c = 1'b0;
            end
        end

        if (READ_LAT == 1) begin : g_reg
            logic [DATA_W-1:0] d_q;
            logic              b_q;

            // Registered read: samples the combinational result each edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_q <= '0;
                    b_q <= 1'b0;
                end else begin
                    d_q <= d_c;
                    b_q <= b_c;
                end
            end

            assign rd_data[i*DATA_W +: DATA_W] = d_q;
            assign rd_busy[i]                  = b_q;
        end else begin : g_comb
            assign rd_data[i*DATA_W +: DATA_W] = d_c;
            assign rd_busy[i]                  = b_c;
        end
    end

endmodule
